voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Schedules incoming note-on/note-off events onto the NUM_CHANNELS synth voices.
- Drives the packed carrier_in, modulator_in and velocity_in buses of fm_synth_top.
- Tracks which voices are held and reads the envelope `available` flags from note_registers.
- Retriggers a voice on a repeated key, steals a voice round-robin when none is free, and provides a one-cycle panic clear.

Parameters:
- NUM_CHANNELS, 16, number of voices; must be a power of two, ≥2.
- NUM_BITS, 32, width of each tuning word and velocity word.
- KEY_BITS, 7, width of the note key identifier.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event; high only in IDLE.
- ev_note_on  in  1  1 = note-on, 0 = note-off.
- ev_key  in  KEY_BITS  key identifier.
- ev_car_word  in  NUM_BITS  carrier tuning word (note-on only).
- ev_mod_word  in  NUM_BITS  modulator tuning word (note-on only).
- ev_velocity  in  NUM_BITS  velocity (note-on only); a note-on with velocity 0 is treated as a note-off.
- panic  in  1  all-notes-off request.
- available  in  NUM_CHANNELS  per-voice envelope-idle flag from note_registers.
- carrier_out  out  NUM_BITS*NUM_CHANNELS  packed carrier words; voice i occupies [i*NUM_BITS +: NUM_BITS].
- modulator_out  out  NUM_BITS*NUM_CHANNELS  packed modulator words.
- velocity_out  out  NUM_BITS*NUM_CHANNELS  packed velocities; 0 = released.
- held_out  out  NUM_CHANNELS  per-voice held flag.
- steal_pulse  out  1  one-cycle pulse on a commit that stole a voice.
- drop_pulse  out  1  one-cycle pulse when a note-off matched no held voice.

Behaviour:
- Reset values: ev_ready=0 during reset and 1 the cycle after; all word buses 0; held_out 0; steal_ptr 0; both pulses 0; state IDLE.
- Per-voice state: held[i], key[i], carrier word, modulator word, velocity.
- A voice is free when `!held[i] && available[i]`.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - Accept on ev_valid && ev_ready. Capture the event into registers, clear the scan flags, idx=0, go to SCAN.
- SCAN:
  - Examines voice idx each cycle, for idx = 0..NUM_CHANNELS-1, using live `available`.
  - Records the first voice with held && key==ev_key (match).
  - Records the lowest-index free voice (free).
  - After idx = NUM_CHANNELS-1, go to COMMIT.
- COMMIT, note-on, target chosen in priority order: match > free > steal_ptr.
  - Write the target's carrier, modulator, velocity and key; set held.
  - If the steal path was taken: steal_ptr <= steal_ptr+1 (wraps modulo NUM_CHANNELS) and steal_pulse=1.
- COMMIT, note-off:
  - If match: held cleared and velocity set to 0; carrier and modulator words are retained so the release tail stays in tune.
  - If no match: no voice change; drop_pulse=1.
- After COMMIT, return to IDLE.
- Timing for an event accepted at cycle T:
  - Scan cycles T+1..T+N; COMMIT at T+N+1; outputs updated from T+N+2.
  - ev_ready high again at T+N+2; maximum throughput is one event per N+2 cycles.
- Only one voice is written per event. Voices not targeted keep their values.
- ev_* inputs are ignored while ev_ready=0. Events are never queued.
- panic has priority over all states:
  - Next cycle: all held=0, all velocities=0, state IDLE, any in-flight event discarded, no pulses.
  - Carrier/modulator words and steal_ptr are kept.
  - ev_ready is 0 in the panic cycle.
  - panic and a simultaneous ev_valid: the event is not accepted.
- rst mid-scan: immediate return to reset values; the in-flight event is lost.
- `available` changing during a scan: the sampled value at that voice's scan cycle is used.
- Duplicate held keys cannot arise, because a note-on retriggers the existing held voice.

Decomposition:
- Shared package fm_synth_pkg holds:
  - the state encoding (IDLE/SCAN/COMMIT localparams);
  - a TOTAL_BITS helper function (NUM_BITS*NUM_CHANNELS);
  - the velocity-zero release constant.
- One natural sub-module, voice_slot: a single voice's storage (key, three words, held) with write/release/panic controls, generated NUM_CHANNELS times.
- Scan and FSM logic stay in voice_allocator.

Test Plan:
1. Reset, all available=1. Note-on key 60, car 0x0100_0000, mod 0x0080_0000, vel 0x7F → voice 0 written at T+18; held_out=0x0001; ev_ready returns at T+18.
2. Note-on keys 60, 62, 64, then note-off 62 → voices 0, 1, 2 held. Voice 1 velocity=0 and held cleared; voice 1 carrier unchanged; held_out=0x0005.
3. Hold 16 distinct keys, then two more note-ons → first steal writes voice 0, second writes voice 1; steal_pulse on each; steal_ptr=2.
4. Note-on key 60 twice, with different vel 0x40 then 0x7F → same voice reused, velocity 0x7F; only one held bit set.
5. Note-off key 99 with nothing held → no bus change; drop_pulse=1 for one cycle at COMMIT.
6. Assert panic during SCAN (and separately rst during SCAN) → next cycle all velocities 0, held_out=0, state IDLE, in-flight event discarded (not committed), ev_ready=1 the cycle after.

Source files
------------

// File: rtl/fm_synth_pkg.sv
// Shared definitions for the FM synth voice allocation path: allocator state
// encoding, bus width helper and the velocity value that marks a released voice.
package fm_synth_pkg;

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_SCAN   = 2'd1;
    localparam logic [1:0] STATE_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = STATE_IDLE,
        ST_SCAN   = STATE_SCAN,
        ST_COMMIT = STATE_COMMIT
    } alloc_state_t;

    // A velocity of zero means the voice is in its release phase.
    localparam int VEL_RELEASE = 0;

    function automatic int total_bits(input int num_bits, input int num_channels);
        return num_bits * num_channels;
    endfunction

endpackage

// File: rtl/voice_slot.sv
// One synth voice: key, carrier/modulator tuning words, velocity and held flag,
// with write, release and panic controls driven by the allocator.
module voice_slot
    import fm_synth_pkg::*;
#(
    parameter int NUM_BITS = 32,
    parameter int KEY_BITS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                panic,
    input  logic                wr,
    input  logic                rel,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic [NUM_BITS-1:0] car_in,
    input  logic [NUM_BITS-1:0] mod_in,
    input  logic [NUM_BITS-1:0] vel_in,
    output logic [KEY_BITS-1:0] key,
    output logic [NUM_BITS-1:0] car,
    output logic [NUM_BITS-1:0] mod,
    output logic [NUM_BITS-1:0] vel,
    output logic                held
);

    // Voice storage; tuning words survive panic and release so tails stay in tune.
    always_ff @(posedge clk) begin
        if (rst) begin
            key  <= '0;
            car  <= '0;
            mod  <= '0;
            vel  <= '0;
            held <= 1'b0;
        end else if (panic) begin
            vel  <= NUM_BITS'(VEL_RELEASE);
            held <= 1'b0;
        end else if (wr) begin
            key  <= key_in;
            car  <= car_in;
            mod  <= mod_in;
            vel  <= vel_in;
            held <= 1'b1;
        end else if (rel) begin
            vel  <= NUM_BITS'(VEL_RELEASE);
            held <= 1'b0;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Maps note-on/note-off events onto synth voices: serial scan for a key match
// and a free voice, then a single-voice commit with round-robin stealing.
module voice_allocator
    import fm_synth_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS     = 32,
    parameter int KEY_BITS     = 7
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             ev_valid,
    output logic                                             ev_ready,
    input  logic                                             ev_note_on,
    input  logic [KEY_BITS-1:0]                              ev_key,
    input  logic [NUM_BITS-1:0]                              ev_car_word,
    input  logic [NUM_BITS-1:0]                              ev_mod_word,
    input  logic [NUM_BITS-1:0]                              ev_velocity,
    input  logic                                             panic,
    input  logic [NUM_CHANNELS-1:0]                          available,
    output logic [total_bits(NUM_BITS, NUM_CHANNELS)-1:0]    carrier_out,
    output logic [total_bits(NUM_BITS, NUM_CHANNELS)-1:0]    modulator_out,
    output logic [total_bits(NUM_BITS, NUM_CHANNELS)-1:0]    velocity_out,
    output logic [NUM_CHANNELS-1:0]                          held_out,
    output logic                                             steal_pulse,
    output logic                                             drop_pulse
);

    localparam int IW = $clog2(NUM_CHANNELS);

    alloc_state_t        state_r;
    logic                ready_r;
    logic [IW-1:0]       idx_r;
    logic                on_r;
    logic [KEY_BITS-1:0] key_r;
    logic [NUM_BITS-1:0] car_r;
    logic [NUM_BITS-1:0] mod_r;
    logic [NUM_BITS-1:0] vel_r;
    logic                match_found_r;
    logic [IW-1:0]       match_idx_r;
    logic                free_found_r;
    logic [IW-1:0]       free_idx_r;
    logic [IW-1:0]       steal_ptr_r;
    logic                steal_pulse_r;
    logic                drop_pulse_r;

    logic                    commit_s;
    logic [IW-1:0]           target_s;
    logic                    steal_s;
    logic [NUM_CHANNELS-1:0] wr_s;
    logic [NUM_CHANNELS-1:0] rel_s;
    logic [NUM_CHANNELS-1:0] held_s;
    logic [KEY_BITS-1:0]     key_s [NUM_CHANNELS];

    assign commit_s    = (state_r == ST_COMMIT);
    assign ev_ready    = ready_r;
    assign held_out    = held_s;
    assign steal_pulse = steal_pulse_r;
    assign drop_pulse  = drop_pulse_r;

    // Commit target priority: retrigger a held match, else lowest free voice, else steal.
    always_comb begin
        target_s = steal_ptr_r;
        steal_s  = 1'b0;
        if (match_found_r) begin
            target_s = match_idx_r;
        end else if (free_found_r) begin
            target_s = free_idx_r;
        end else begin
            target_s = steal_ptr_r;
            steal_s  = on_r;
        end
    end

    // Allocator FSM with event capture, per-voice scan and commit bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ready_r       <= 1'b0;
            idx_r         <= '0;
            on_r          <= 1'b0;
            key_r         <= '0;
            car_r         <= '0;
            mod_r         <= '0;
            vel_r         <= '0;
            match_found_r <= 1'b0;
            match_idx_r   <= '0;
            free_found_r  <= 1'b0;
            free_idx_r    <= '0;
            steal_ptr_r   <= '0;
            steal_pulse_r <= 1'b0;
            drop_pulse_r  <= 1'b0;
        end else if (panic) begin
            state_r       <= ST_IDLE;
            ready_r       <= 1'b0;
            match_found_r <= 1'b0;
            free_found_r  <= 1'b0;
            steal_pulse_r <= 1'b0;
            drop_pulse_r  <= 1'b0;
        end else begin
            steal_pulse_r <= 1'b0;
            drop_pulse_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b1;
                    if (ev_valid && ready_r) begin
                        // A zero-velocity note-on is a note-off.
                        on_r          <= ev_note_on && (ev_velocity != '0);
                        key_r         <= ev_key;
                        car_r         <= ev_car_word;
                        mod_r         <= ev_mod_word;
                        vel_r         <= ev_velocity;
                        match_found_r <= 1'b0;
                        free_found_r  <= 1'b0;
                        idx_r         <= '0;
                        ready_r       <= 1'b0;
                        state_r       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!match_found_r && held_s[idx_r] && (key_s[idx_r] == key_r)) begin
                        match_found_r <= 1'b1;
                        match_idx_r   <= idx_r;
                    end
                    if (!free_found_r && !held_s[idx_r] && available[idx_r]) begin
                        free_found_r <= 1'b1;
                        free_idx_r   <= idx_r;
                    end
                    if (idx_r == IW'(NUM_CHANNELS - 1)) begin
                        state_r <= ST_COMMIT;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                ST_COMMIT: begin
                    if (steal_s) begin
                        steal_ptr_r   <= steal_ptr_r + IW'(1);
                        steal_pulse_r <= 1'b1;
                    end
                    drop_pulse_r <= !on_r && !match_found_r;
                    ready_r      <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_voice
        assign wr_s[i]  = commit_s && on_r && (target_s == IW'(i));
        assign rel_s[i] = commit_s && !on_r && match_found_r && (match_idx_r == IW'(i));

        voice_slot #(
            .NUM_BITS (NUM_BITS),
            .KEY_BITS (KEY_BITS)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .panic  (panic),
            .wr     (wr_s[i]),
            .rel    (rel_s[i]),
            .key_in (key_r),
            .car_in (car_r),
            .mod_in (mod_r),
            .vel_in (vel_r),
            .key    (key_s[i]),
            .car    (carrier_out[i*NUM_BITS +: NUM_BITS]),
            .mod    (modulator_out[i*NUM_BITS +: NUM_BITS]),
            .vel    (velocity_out[i*NUM_BITS +: NUM_BITS]),
            .held   (held_s[i])
        );
    end

endmodule
